// File: rtl/mc_bus_responder.sv
// Responder for the MCU asynchronous parallel memory bus: synchronises and filters the strobes,
// turns writes into one-cycle register-file writes and reads into request/response bus cycles.
module mc_bus_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADD_WIDTH   = 6,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 2,
    parameter int RD_TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mc_ce_n,
    input  logic                  mc_we_n,
    input  logic                  mc_oe_n,
    input  logic [ADD_WIDTH-1:0]  mc_add,
    input  logic [DATA_WIDTH-1:0] mc_data_in,
    output logic [DATA_WIDTH-1:0] mc_data_out,
    output logic                  mc_data_oe,
    output logic                  wr_valid,
    output logic [ADD_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_req,
    output logic [ADD_WIDTH-1:0]  rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  err_proto,
    output logic                  err_timeout
);

    localparam int PW = $clog2(MIN_PULSE + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [PW-1:0] P_MAX = PW'(MIN_PULSE - 1);
    localparam logic [TW-1:0] T_MAX = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_DRIVE
    } state_t;

    logic [SYNC_STAGES-1:0] ce_sr, we_sr, oe_sr;
    logic [ADD_WIDTH-1:0]   add_pipe  [SYNC_STAGES];
    logic [DATA_WIDTH-1:0]  data_pipe [SYNC_STAGES];

    // NOTE: the address/data pipelines are plain flops rather than RAM, so they are reset to keep
    // the first sampled add/data defined; a true memory array would be left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_sr <= '1;
            we_sr <= '1;
            oe_sr <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                add_pipe[i]  <= '0;
                data_pipe[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            ce_sr <= {ce_sr[SYNC_STAGES-2:0], mc_ce_n};
            we_sr <= {we_sr[SYNC_STAGES-2:0], mc_we_n};
            oe_sr <= {oe_sr[SYNC_STAGES-2:0], mc_oe_n};
            add_pipe[0]  <= mc_add;
            data_pipe[0] <= mc_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                add_pipe[i]  <= add_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    logic                  ce_s, we_s, oe_s;
    logic [ADD_WIDTH-1:0]  add_s;
    logic [DATA_WIDTH-1:0] data_s;
    assign ce_s   = ce_sr[SYNC_STAGES-1];
    assign we_s   = we_sr[SYNC_STAGES-1];
    assign oe_s   = oe_sr[SYNC_STAGES-1];
    assign add_s  = add_pipe[SYNC_STAGES-1];
    assign data_s = data_pipe[SYNC_STAGES-1];

    // Each counter holds the number of earlier consecutive low samples, saturating one short of MIN_PULSE.
    logic [PW-1:0] we_cnt, oe_cnt;
    logic          we_now, oe_now, we_low, oe_low;
    assign we_now = ~we_s & ~ce_s;
    assign oe_now = ~oe_s & ~ce_s;
    assign we_low = we_now && (we_cnt == P_MAX);
    assign oe_low = oe_now && (oe_cnt == P_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_cnt <= '0;
            oe_cnt <= '0;
        end else begin
            we_cnt <= !we_now ? '0 : (we_cnt == P_MAX) ? we_cnt : we_cnt + 1'b1;
            oe_cnt <= !oe_now ? '0 : (oe_cnt == P_MAX) ? oe_cnt : oe_cnt + 1'b1;
        end
    end

    state_t                state;
    logic                  err_lock;
    logic                  drive_q;
    logic [TW-1:0]         tmr;
    logic [ADD_WIDTH-1:0]  sh_addr;
    logic [DATA_WIDTH-1:0] sh_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            err_lock    <= 1'b0;
            drive_q     <= 1'b0;
            tmr         <= '0;
            sh_addr     <= '0;
            sh_data     <= '0;
            mc_data_out <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wr_valid    <= 1'b0;
            rd_req      <= 1'b0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
            if (we_s && oe_s) err_lock <= 1'b0;

            case (state)
                IDLE: begin
                    if (!err_lock) begin
                        if (we_low && oe_low) begin
                            err_proto <= 1'b1;
                            err_lock  <= 1'b1;
                        end else if (we_low) begin
                            sh_addr <= add_s;
                            sh_data <= data_s;
                            state   <= WR;
                        end else if (oe_low) begin
                            rd_req  <= 1'b1;
                            rd_addr <= add_s;
                            tmr     <= '0;
                            state   <= RD_REQ;
                        end
                    end
                end

                WR: begin
                    if (ce_s) begin
                        state <= IDLE;
                    end else if (we_s) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= sh_addr;
                        wr_data  <= sh_data;
                        state    <= IDLE;
                    end else begin
                        sh_addr <= add_s;
                        sh_data <= data_s;
                    end
                end

                // rd_valid is accepted from the request cycle on, so zero-latency returns also work.
                RD_REQ, RD_WAIT: begin
                    if (ce_s) begin
                        state <= IDLE;
                    end else if (rd_valid || tmr == T_MAX) begin
                        err_timeout <= !rd_valid;
                        if (!oe_s) begin
                            mc_data_out <= rd_valid ? rd_data : '0;
                            drive_q     <= 1'b1;
                            state       <= RD_DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmr   <= tmr + 1'b1;
                        state <= RD_WAIT;
                    end
                end

                RD_DRIVE: begin
                    if (ce_s || oe_s) begin
                        drive_q     <= 1'b0;
                        mc_data_out <= '0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Contention guard: the pad driver drops in the same cycle the synchronised OE or CE goes high.
    assign mc_data_oe = drive_q && (state == RD_DRIVE) && !oe_s && !ce_s;

endmodule

// File: tb/tb_mc_bus_responder.sv
// Directed bench for mc_bus_responder: write, read, glitch, protocol error, timeout, abort and reset,
// with latencies measured in clocks from the bench's own stimulus edges.
module tb_mc_bus_responder;

    localparam int DW = 16, AW = 6, SYNC = 2, MINP = 2, RTO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mc_ce_n = 1'b1, mc_we_n = 1'b1, mc_oe_n = 1'b1;
    logic [AW-1:0] mc_add = '0;
    logic [DW-1:0] mc_data_in = '0;
    logic [DW-1:0] mc_data_out;
    logic          mc_data_oe;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          err_proto, err_timeout;

    mc_bus_responder #(
        .DATA_WIDTH(DW), .ADD_WIDTH(AW), .SYNC_STAGES(SYNC), .MIN_PULSE(MINP), .RD_TIMEOUT(RTO)
    ) dut (
        .clk(clk), .rst(rst),
        .mc_ce_n(mc_ce_n), .mc_we_n(mc_we_n), .mc_oe_n(mc_oe_n),
        .mc_add(mc_add), .mc_data_in(mc_data_in),
        .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampling on the falling edge.
    int            wr_seen = 0, rd_seen = 0, ep_seen = 0, to_seen = 0, oe_seen = 0;
    int            wr_cyc = 0, to_cyc = 0, oe_last = 0;
    logic [AW-1:0] wr_a = '0, rd_a = '0;
    logic [DW-1:0] wr_d = '0;
    always @(negedge clk) begin
        if (wr_valid) begin wr_seen++; wr_cyc = cyc; wr_a = wr_addr; wr_d = wr_data; end
        if (rd_req) begin rd_seen++; rd_a = rd_addr; end
        if (err_proto) ep_seen++;
        if (err_timeout) begin to_seen++; to_cyc = cyc; end
        if (mc_data_oe) begin oe_seen++; oe_last = cyc; end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rd_req(input string tag);
        int k;
        k = 0;
        while (!rd_req && k < 30) begin
            step(1);
            k++;
        end
        check({tag, "_rd_req_seen"}, 32'(rd_req), 1);
    endtask

    // Full write cycle; returns the cycle at which we_n was released.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int low, output int n_rise);
        mc_ce_n = 1'b0; mc_add = a; mc_data_in = d;
        step(3);
        mc_we_n = 1'b0;
        step(low);
        mc_we_n = 1'b1;
        n_rise = cyc;
        step(3);
        mc_ce_n = 1'b1;
        step(6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, m, r, s_wr, s_rd, s_ep, s_oe, s_to;

        step(3);
        check("rst_oe", 32'(mc_data_oe), 0);
        check("rst_data_out", 32'(mc_data_out), 0);
        check("rst_wr_valid", 32'(wr_valid), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_err_proto", 32'(err_proto), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        rst = 1'b1;
        step(4);

        // 1. plain write
        s_wr = wr_seen;
        do_write(6'h01, 16'h00FF, 6, n);
        check("t1_wr_count", 32'(wr_seen - s_wr), 1);
        check("t1_wr_addr", 32'(wr_a), 32'h01);
        check("t1_wr_data", 32'(wr_d), 32'h00FF);
        check("t1_wr_latency", 32'(wr_cyc - n), SYNC + 1);

        // 2. read with one-clock return latency
        s_rd = rd_seen;
        mc_ce_n = 1'b0; mc_add = 6'h00;
        step(3);
        mc_oe_n = 1'b0;
        n = cyc;
        wait_rd_req("t2");
        check("t2_rd_latency", 32'(cyc - n), SYNC + MINP);
        check("t2_rd_addr", 32'(rd_addr), 32'h00);
        step(1);
        rd_valid = 1'b1; rd_data = 16'hA5C3;
        step(1);
        rd_valid = 1'b0; rd_data = 16'h0000;
        check("t2_oe_on", 32'(mc_data_oe), 1);
        check("t2_data_out", 32'(mc_data_out), 32'hA5C3);
        mc_oe_n = 1'b1;
        m = cyc;
        step(6);
        check("t2_oe_release_window", 32'((oe_last - m) >= 1 && (oe_last - m) <= SYNC + 1), 1);
        check("t2_oe_off", 32'(mc_data_oe), 0);
        check("t2_rd_count", 32'(rd_seen - s_rd), 1);
        mc_ce_n = 1'b1;
        step(3);

        // 3. one-clock WE glitch
        s_wr = wr_seen; s_ep = ep_seen;
        mc_ce_n = 1'b0;
        step(3);
        mc_we_n = 1'b0;
        step(1);
        mc_we_n = 1'b1;
        step(8);
        mc_ce_n = 1'b1;
        step(3);
        check("t3_no_wr", 32'(wr_seen - s_wr), 0);
        check("t3_no_err", 32'(ep_seen - s_ep), 0);

        // 4. WE and OE low together
        s_wr = wr_seen; s_rd = rd_seen; s_ep = ep_seen; s_oe = oe_seen;
        mc_ce_n = 1'b0;
        step(3);
        mc_we_n = 1'b0; mc_oe_n = 1'b0;
        step(6);
        mc_we_n = 1'b1; mc_oe_n = 1'b1;
        step(6);
        mc_ce_n = 1'b1;
        step(3);
        check("t4_err_proto_count", 32'(ep_seen - s_ep), 1);
        check("t4_no_wr", 32'(wr_seen - s_wr), 0);
        check("t4_no_rd", 32'(rd_seen - s_rd), 0);
        check("t4_no_drive", 32'(oe_seen - s_oe), 0);

        // 5. read timeout; rd_data is non-zero but never valid
        s_to = to_seen;
        rd_data = 16'hFFFF;
        mc_ce_n = 1'b0; mc_add = 6'h03;
        step(3);
        mc_oe_n = 1'b0;
        n = cyc;
        wait_rd_req("t5");
        r = cyc;
        check("t5_rd_addr", 32'(rd_addr), 32'h03);
        step(n + 15 - cyc);
        check("t5_timeout_count", 32'(to_seen - s_to), 1);
        check("t5_timeout_latency", 32'(to_cyc - r), RTO);
        check("t5_oe_on", 32'(mc_data_oe), 1);
        check("t5_data_zero", 32'(mc_data_out), 0);
        step(n + 20 - cyc);
        mc_oe_n = 1'b1;
        step(6);
        check("t5_oe_off", 32'(mc_data_oe), 0);
        mc_ce_n = 1'b1; rd_data = 16'h0000;
        step(3);

        // 6a. CE released mid-write, then a normal write must still work
        s_wr = wr_seen;
        mc_ce_n = 1'b0; mc_add = 6'h05; mc_data_in = 16'h1234;
        step(3);
        mc_we_n = 1'b0;
        step(5);
        mc_ce_n = 1'b1;
        step(3);
        mc_we_n = 1'b1;
        step(8);
        check("t6_abort_no_wr", 32'(wr_seen - s_wr), 0);
        do_write(6'h02, 16'hBEEF, 4, n);
        check("t6_post_abort_wr_count", 32'(wr_seen - s_wr), 1);
        check("t6_post_abort_wr_addr", 32'(wr_a), 32'h02);
        check("t6_post_abort_wr_data", 32'(wr_d), 32'hBEEF);

        // 6b. asynchronous reset while driving the bus
        mc_ce_n = 1'b0; mc_add = 6'h07;
        step(3);
        mc_oe_n = 1'b0;
        wait_rd_req("t6");
        step(1);
        rd_valid = 1'b1; rd_data = 16'h5A5A;
        step(1);
        rd_valid = 1'b0; rd_data = 16'h0000;
        check("t6_drive_before_rst", 32'(mc_data_oe), 1);
        #3 rst = 1'b0;
        #1;
        check("t6_rst_oe_async", 32'(mc_data_oe), 0);
        check("t6_rst_data_out", 32'(mc_data_out), 0);
        mc_oe_n = 1'b1; mc_ce_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(4);
        s_wr = wr_seen;
        do_write(6'h09, 16'h1357, 6, n);
        check("t6_post_rst_wr_count", 32'(wr_seen - s_wr), 1);
        check("t6_post_rst_wr_data", 32'(wr_d), 32'h1357);
        check("t6_post_rst_wr_latency", 32'(wr_cyc - n), SYNC + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
